// File: rtl/lsu_arbiter_if.sv
// One requester's channel into the LSU arbiter (used for both the CPU MEM stage and the debug port).
// req/gnt form a valid/accept pair: a transfer happens in any cycle with req & gnt; while req & ~gnt
// the requester holds we/addr/wdata/sel stable, and may drop req before a grant (no access occurs).
// rvalid is a 1-cycle pulse, one cycle after a granted load.
interface lsu_arbiter_if #(
    parameter int AW = 12
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    sel;
    logic          gnt;
    logic          rvalid;

    modport master (output req, we, addr, wdata, sel, input gnt, rvalid);
    modport slave  (input req, we, addr, wdata, sel, output gnt, rvalid);
endinterface

// File: rtl/lsu_arbiter.sv
// Shares the single LSU data port between the CPU MEM stage and the debug/loader port.
// CPU has fixed priority; a starvation counter and a DBG lock keep the debug port serviceable.
module lsu_arbiter #(
    parameter int WAIT_MAX = 8,
    parameter int AW       = 12
) (
    input  logic                               clk,
    input  logic                               reset_n,
    lsu_arbiter_if.slave                       cpu,
    lsu_arbiter_if.slave                       dbg,
    input  logic                               dbg_lock_i,
    output logic                               cpu_stall_o,
    output logic [31:0]                        rdata_o,
    output logic [AW-1:0]                      lsu_addr_o,
    output logic [31:0]                        lsu_st_data_o,
    output logic                               lsu_st_en_o,
    output logic [2:0]                         lsu_sel_o,
    input  logic [31:0]                        lsu_ld_data_i,
    output logic                               dbg_state_o,
    output logic [$clog2(WAIT_MAX+1)-1:0]      dbg_wait_cnt_o
);

    localparam int            CW         = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX_C = CW'(WAIT_MAX);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          cpu_rv_q, cpu_rv_d;
    logic          dbg_rv_q, dbg_rv_d;

    logic          cpu_gnt;
    logic          dbg_gnt;
    logic          arb_rules;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= '0;
            cpu_rv_q   <= 1'b0;
            dbg_rv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cpu_rv_q   <= cpu_rv_d;
            dbg_rv_q   <= dbg_rv_d;
        end
    end

    // Next-state: a lock is only entered on a DBG grant and is released the first cycle lock drops.
    always_comb begin
        state_d = ST_ARB;
        if (dbg_lock_i && (dbg_gnt || state_q == ST_LOCK)) begin
            state_d = ST_LOCK;
        end

        wait_cnt_d = wait_cnt_q;
        if (dbg_gnt || !dbg.req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX_C) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        cpu_rv_d = cpu_gnt & ~cpu.we;
        dbg_rv_d = dbg_gnt & ~dbg.we;
    end

    // Outputs: grants and the LSU mux are combinational and forced quiet while reset is asserted.
    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        arb_rules = (state_q == ST_ARB) || !dbg_lock_i;

        if (reset_n) begin
            if (!arb_rules) begin
                dbg_gnt = dbg.req;
            end else if (dbg.req && wait_cnt_q == WAIT_MAX_C) begin
                dbg_gnt = 1'b1;
            end else if (cpu.req) begin
                cpu_gnt = 1'b1;
            end else if (dbg.req) begin
                dbg_gnt = 1'b1;
            end
        end

        cpu.gnt     = cpu_gnt;
        dbg.gnt     = dbg_gnt;
        cpu_stall_o = reset_n & cpu.req & ~cpu_gnt;

        lsu_addr_o    = '0;
        lsu_st_data_o = '0;
        lsu_sel_o     = '0;
        lsu_st_en_o   = 1'b0;
        if (cpu_gnt) begin
            lsu_addr_o    = cpu.addr;
            lsu_st_data_o = cpu.wdata;
            lsu_sel_o     = cpu.sel;
            lsu_st_en_o   = cpu.we;
        end else if (dbg_gnt) begin
            lsu_addr_o    = dbg.addr;
            lsu_st_data_o = dbg.wdata;
            lsu_sel_o     = dbg.sel;
            lsu_st_en_o   = dbg.we;
        end

        cpu.rvalid     = cpu_rv_q;
        dbg.rvalid     = dbg_rv_q;
        rdata_o        = reset_n ? lsu_ld_data_i : 32'h0;
        dbg_state_o    = state_q;
        dbg_wait_cnt_o = wait_cnt_q;
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios plus a randomized run against a queue-based reference model.
module tb_lsu_arbiter;

    localparam int AW       = 12;
    localparam int WAIT_MAX = 8;
    localparam int CW       = $clog2(WAIT_MAX + 1);

    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'h2222_0001;
    localparam logic [31:0] W2 = 32'h3333_0002;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dbg_lock;
    logic          cpu_stall;
    logic [31:0]   rdata;
    logic [AW-1:0] lsu_addr;
    logic [31:0]   lsu_st_data;
    logic          lsu_st_en;
    logic [2:0]    lsu_sel;
    logic [31:0]   lsu_ld_data;
    logic          dbg_state;
    logic [CW-1:0] dbg_wait_cnt;

    lsu_arbiter_if #(.AW(AW)) cpu_if ();
    lsu_arbiter_if #(.AW(AW)) dbg_if ();

    lsu_arbiter #(.WAIT_MAX(WAIT_MAX), .AW(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu            (cpu_if),
        .dbg            (dbg_if),
        .dbg_lock_i     (dbg_lock),
        .cpu_stall_o    (cpu_stall),
        .rdata_o        (rdata),
        .lsu_addr_o     (lsu_addr),
        .lsu_st_data_o  (lsu_st_data),
        .lsu_st_en_o    (lsu_st_en),
        .lsu_sel_o      (lsu_sel),
        .lsu_ld_data_i  (lsu_ld_data),
        .dbg_state_o    (dbg_state),
        .dbg_wait_cnt_o (dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- LSU stand-in: word memory, load data one cycle later ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] ld_q;
    always @(posedge clk) begin
        if (lsu_st_en) mem[lsu_addr[AW-1:2]] <= lsu_st_data;
        ld_q <= mem[lsu_addr[AW-1:2]];
    end
    assign lsu_ld_data = ld_q;

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] shadow [0:1023];
    logic [32:0] exp_q[$];      // {owner (1=dbg), data} of loads due back next cycle
    int          m_refused;     // consecutive cycles DBG asked and was refused
    bit          m_locked;      // DBG currently owns the port
    int          n_checks = 0;
    int          n_pass   = 0;

    logic          e_cpu_gnt, e_dbg_gnt, e_stall, e_st_en, e_cpu_rv, e_dbg_rv, e_state;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_rdata;
    logic [2:0]    e_sel;
    logic [CW-1:0] e_wait;

    task automatic model_reset();
        m_refused = 0;
        m_locked  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_eval();
        e_cpu_gnt = 1'b0;
        e_dbg_gnt = 1'b0;
        if (m_locked && dbg_lock)                        e_dbg_gnt = dbg_if.req;
        else if (dbg_if.req && m_refused >= WAIT_MAX)    e_dbg_gnt = 1'b1;
        else if (cpu_if.req)                             e_cpu_gnt = 1'b1;
        else                                             e_dbg_gnt = dbg_if.req;
        e_stall = cpu_if.req && !e_cpu_gnt;
        e_st_en = 1'b0; e_addr = '0; e_wdata = '0; e_sel = '0;
        if (e_cpu_gnt) begin
            e_st_en = cpu_if.we; e_addr = cpu_if.addr; e_wdata = cpu_if.wdata; e_sel = cpu_if.sel;
        end
        if (e_dbg_gnt) begin
            e_st_en = dbg_if.we; e_addr = dbg_if.addr; e_wdata = dbg_if.wdata; e_sel = dbg_if.sel;
        end
        e_cpu_rv = (exp_q.size() != 0) && !exp_q[0][32];
        e_dbg_rv = (exp_q.size() != 0) && exp_q[0][32];
        e_rdata  = (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0;
        e_wait   = (m_refused >= WAIT_MAX) ? CW'(WAIT_MAX) : CW'(m_refused);
        e_state  = m_locked;
    endtask

    task automatic model_commit();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (e_cpu_gnt) begin
            if (cpu_if.we) shadow[cpu_if.addr[AW-1:2]] = cpu_if.wdata;
            else           exp_q.push_back({1'b0, shadow[cpu_if.addr[AW-1:2]]});
        end
        if (e_dbg_gnt) begin
            if (dbg_if.we) shadow[dbg_if.addr[AW-1:2]] = dbg_if.wdata;
            else           exp_q.push_back({1'b1, shadow[dbg_if.addr[AW-1:2]]});
        end
        m_refused = (dbg_if.req && !e_dbg_gnt) ? m_refused + 1 : 0;
        m_locked  = dbg_lock && (m_locked || e_dbg_gnt);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, input logic [2:0] sel);
        cpu_if.req = req; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.sel = sel;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] addr,
                             input logic [31:0] wdata, input logic [2:0] sel, input logic lock);
        dbg_if.req = req; dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata; dbg_if.sel = sel;
        dbg_lock = lock;
    endtask

    task automatic drive_idle();
        drive_cpu(1'b0, 1'b0, '0, '0, '0);
        drive_dbg(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 15) << 2);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        drive_idle();
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b0) $display("FAIL rst_cpu_gnt: got %b want 0", cpu_if.gnt); else n_pass++;
        n_checks++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", cpu_stall); else n_pass++;
        n_checks++; if (lsu_addr !== '0) $display("FAIL rst_lsu_addr: got %h want 0", lsu_addr); else n_pass++;
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        settle();
        n_checks++; if (dbg_state !== 1'b0) $display("FAIL rst_state: got %b want 0", dbg_state); else n_pass++;
        n_checks++; if (dbg_wait_cnt !== '0) $display("FAIL rst_wait_cnt: got %0d want 0", dbg_wait_cnt); else n_pass++;
        n_checks++; if (cpu_if.rvalid !== 1'b0) $display("FAIL rst_cpu_rvalid: got %b want 0", cpu_if.rvalid); else n_pass++;
        advance();

        // Load granted, then reset the very next cycle: the return must be discarded.
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL midload_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (cpu_if.rvalid !== 1'b0) $display("FAIL midload_rvalid: got %b want 0", cpu_if.rvalid); else n_pass++;
        n_checks++; if (cpu_if.gnt !== 1'b0 || dbg_if.gnt !== 1'b0) $display("FAIL midload_gnts: got %b%b want 00", cpu_if.gnt, dbg_if.gnt); else n_pass++;
        n_checks++; if (cpu_stall !== 1'b0) $display("FAIL midload_stall: got %b want 0", cpu_stall); else n_pass++;
        n_checks++; if (lsu_st_en !== 1'b0 || lsu_addr !== '0 || lsu_sel !== '0 || lsu_st_data !== '0)
            $display("FAIL midload_lsu: got en=%b addr=%h want all 0", lsu_st_en, lsu_addr); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL midload_rdata: got %h want 0", rdata); else n_pass++;
        drive_idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        settle();
        n_checks++; if (cpu_if.rvalid !== 1'b0) $display("FAIL midload_after_rvalid: got %b want 0", cpu_if.rvalid); else n_pass++;
        advance();
    endtask

    task automatic test_cpu_only();
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL cpu_ld_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        n_checks++; if (lsu_st_en !== 1'b0) $display("FAIL cpu_ld_st_en: got %b want 0", lsu_st_en); else n_pass++;
        n_checks++; if (lsu_addr !== 12'h010) $display("FAIL cpu_ld_addr: got %h want 010", lsu_addr); else n_pass++;
        n_checks++; if (lsu_sel !== 3'b010) $display("FAIL cpu_ld_sel: got %b want 010", lsu_sel); else n_pass++;
        advance();
        drive_cpu(1'b1, 1'b1, 12'h014, 32'hDEAD_BEEF, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL cpu_st_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        n_checks++; if (lsu_st_en !== 1'b1) $display("FAIL cpu_st_en: got %b want 1", lsu_st_en); else n_pass++;
        n_checks++; if (lsu_st_data !== 32'hDEAD_BEEF) $display("FAIL cpu_st_data: got %h want deadbeef", lsu_st_data); else n_pass++;
        n_checks++; if (cpu_if.rvalid !== 1'b1) $display("FAIL cpu_ld_rvalid: got %b want 1", cpu_if.rvalid); else n_pass++;
        n_checks++; if (rdata !== 32'hA500_0004) $display("FAIL cpu_ld_rdata: got %h want a5000004", rdata); else n_pass++;
        advance();
        drive_cpu(1'b1, 1'b0, 12'h014, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.rvalid !== 1'b0) $display("FAIL cpu_st_no_rvalid: got %b want 0", cpu_if.rvalid); else n_pass++;
        n_checks++; if (lsu_st_en !== 1'b0) $display("FAIL cpu_st_en_once: got %b want 0", lsu_st_en); else n_pass++;
        advance();
        drive_idle();
        settle();
        n_checks++; if (cpu_if.rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF)
            $display("FAIL cpu_readback: got rv=%b %h want rv=1 deadbeef", cpu_if.rvalid, rdata); else n_pass++;
        advance();
        settle();
        advance();
    endtask

    task automatic test_starvation();
        drive_cpu(1'b1, 1'b0, 12'h020, 32'h0, 3'b000);
        drive_dbg(1'b1, 1'b0, 12'h040, 32'h0, 3'b000, 1'b0);
        for (int c = 1; c <= 27; c++) begin
            bit want_dbg;
            want_dbg = (c % 9 == 0);
            settle();
            n_checks++; if (dbg_if.gnt !== want_dbg) $display("FAIL starve_dbg_gnt c%0d: got %b want %b", c, dbg_if.gnt, want_dbg); else n_pass++;
            n_checks++; if (cpu_if.gnt !== !want_dbg) $display("FAIL starve_cpu_gnt c%0d: got %b want %b", c, cpu_if.gnt, !want_dbg); else n_pass++;
            n_checks++; if (cpu_stall !== want_dbg) $display("FAIL starve_stall c%0d: got %b want %b", c, cpu_stall, want_dbg); else n_pass++;
            advance();
        end
        drive_idle();
        settle();
        advance();
    endtask

    task automatic test_lock();
        logic [31:0] words [3];
        words[0] = W0; words[1] = W1; words[2] = W2;
        drive_cpu(1'b1, 1'b0, 12'h030, 32'h0, 3'b000);
        drive_dbg(1'b1, 1'b1, 12'h100, W0, 3'b010, 1'b1);
        // First DBG word only gets in through the starvation path.
        for (int c = 1; c <= WAIT_MAX; c++) begin
            settle();
            n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL lock_pre_cpu_gnt c%0d: got %b want 1", c, cpu_if.gnt); else n_pass++;
            advance();
        end
        for (int w = 0; w < 3; w++) begin
            drive_dbg(1'b1, 1'b1, AW'(12'h100 + w * 4), words[w], 3'b010, 1'b1);
            settle();
            n_checks++; if (dbg_if.gnt !== 1'b1) $display("FAIL lock_dbg_gnt w%0d: got %b want 1", w, dbg_if.gnt); else n_pass++;
            n_checks++; if (cpu_if.gnt !== 1'b0) $display("FAIL lock_cpu_gnt w%0d: got %b want 0", w, cpu_if.gnt); else n_pass++;
            n_checks++; if (cpu_stall !== 1'b1) $display("FAIL lock_stall w%0d: got %b want 1", w, cpu_stall); else n_pass++;
            advance();
        end
        drive_dbg(1'b0, 1'b0, '0, '0, '0, 1'b0);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL lock_release_cpu_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        advance();
        drive_idle();
        settle();
        n_checks++; if (dbg_state !== 1'b0) $display("FAIL lock_release_state: got %b want 0", dbg_state); else n_pass++;
        advance();
        for (int w = 0; w < 3; w++) begin
            n_checks++; if (mem[10'h040 + w] !== words[w]) $display("FAIL lock_mem w%0d: got %h want %h", w, mem[10'h040 + w], words[w]); else n_pass++;
        end
    endtask

    task automatic test_interleaved();
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL il_c1_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        advance();
        drive_cpu(1'b0, 1'b0, '0, '0, '0);
        drive_dbg(1'b1, 1'b0, 12'h100, 32'h0, 3'b010, 1'b0);
        settle();
        n_checks++; if (dbg_if.gnt !== 1'b1) $display("FAIL il_c2_gnt: got %b want 1", dbg_if.gnt); else n_pass++;
        n_checks++; if (cpu_if.rvalid !== 1'b1 || dbg_if.rvalid !== 1'b0 || rdata !== 32'hA500_0004)
            $display("FAIL il_rv1: got c%b d%b %h want c1 d0 a5000004", cpu_if.rvalid, dbg_if.rvalid, rdata); else n_pass++;
        advance();
        drive_dbg(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive_cpu(1'b1, 1'b0, 12'h104, 32'h0, 3'b010);
        settle();
        n_checks++; if (cpu_if.gnt !== 1'b1) $display("FAIL il_c3_gnt: got %b want 1", cpu_if.gnt); else n_pass++;
        n_checks++; if (dbg_if.rvalid !== 1'b1 || cpu_if.rvalid !== 1'b0 || rdata !== W0)
            $display("FAIL il_rv2: got c%b d%b %h want c0 d1 %h", cpu_if.rvalid, dbg_if.rvalid, rdata, W0); else n_pass++;
        advance();
        drive_idle();
        settle();
        n_checks++; if (cpu_if.rvalid !== 1'b1 || dbg_if.rvalid !== 1'b0 || rdata !== W1)
            $display("FAIL il_rv3: got c%b d%b %h want c1 d0 %h", cpu_if.rvalid, dbg_if.rvalid, rdata, W1); else n_pass++;
        advance();
    endtask

    task automatic test_idle();
        drive_idle();
        for (int c = 0; c < 10; c++) begin
            settle();
            n_checks++; if (lsu_st_en !== 1'b0) $display("FAIL idle_st_en c%0d: got %b want 0", c, lsu_st_en); else n_pass++;
            n_checks++; if (cpu_if.rvalid !== 1'b0 || dbg_if.rvalid !== 1'b0)
                $display("FAIL idle_rvalid c%0d: got %b%b want 00", c, cpu_if.rvalid, dbg_if.rvalid); else n_pass++;
            n_checks++; if (dbg_wait_cnt !== '0) $display("FAIL idle_wait_cnt c%0d: got %0d want 0", c, dbg_wait_cnt); else n_pass++;
            advance();
        end
    endtask

    task automatic test_random();
        bit cpu_pend = 1'b0;
        bit dbg_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (cpu_pend) begin
                if ($urandom_range(0, 7) == 0) cpu_if.req = 1'b0;
            end else begin
                drive_cpu(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), rand_addr(), $urandom(), 3'($urandom_range(0, 7)));
            end
            if (dbg_pend) begin
                if ($urandom_range(0, 7) == 0) dbg_if.req = 1'b0;
            end else begin
                dbg_if.req = 1'($urandom_range(0, 1)); dbg_if.we = 1'($urandom_range(0, 1));
                dbg_if.addr = rand_addr(); dbg_if.wdata = $urandom(); dbg_if.sel = 3'($urandom_range(0, 7));
            end
            dbg_lock = ($urandom_range(0, 3) == 0);
            settle();
            n_checks++; if (cpu_if.gnt !== e_cpu_gnt) $display("FAIL rnd_cpu_gnt c%0d: got %b want %b", c, cpu_if.gnt, e_cpu_gnt); else n_pass++;
            n_checks++; if (dbg_if.gnt !== e_dbg_gnt) $display("FAIL rnd_dbg_gnt c%0d: got %b want %b", c, dbg_if.gnt, e_dbg_gnt); else n_pass++;
            n_checks++; if (cpu_stall !== e_stall) $display("FAIL rnd_stall c%0d: got %b want %b", c, cpu_stall, e_stall); else n_pass++;
            n_checks++; if (lsu_st_en !== e_st_en || lsu_addr !== e_addr || lsu_st_data !== e_wdata || lsu_sel !== e_sel)
                $display("FAIL rnd_lsu c%0d: got %b %h %h %b want %b %h %h %b", c, lsu_st_en, lsu_addr, lsu_st_data, lsu_sel,
                         e_st_en, e_addr, e_wdata, e_sel); else n_pass++;
            n_checks++; if (cpu_if.rvalid !== e_cpu_rv || dbg_if.rvalid !== e_dbg_rv)
                $display("FAIL rnd_rvalid c%0d: got c%b d%b want c%b d%b", c, cpu_if.rvalid, dbg_if.rvalid, e_cpu_rv, e_dbg_rv); else n_pass++;
            if (e_cpu_rv || e_dbg_rv) begin
                n_checks++; if (rdata !== e_rdata) $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, e_rdata); else n_pass++;
            end
            n_checks++; if (dbg_state !== e_state) $display("FAIL rnd_state c%0d: got %b want %b", c, dbg_state, e_state); else n_pass++;
            n_checks++; if (dbg_wait_cnt !== e_wait) $display("FAIL rnd_wait_cnt c%0d: got %0d want %0d", c, dbg_wait_cnt, e_wait); else n_pass++;
            cpu_pend = cpu_if.req && !e_cpu_gnt;
            dbg_pend = dbg_if.req && !e_dbg_gnt;
            advance();
        end
        drive_idle();
        settle();
        advance();
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'hA500_0000 + 32'(i);
            shadow[i] = 32'hA500_0000 + 32'(i);
        end
        drive_idle();
        test_reset();
        test_cpu_only();
        test_starvation();
        test_lock();
        test_interleaved();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
